// File: rtl/divider_seq64.sv
// divider_seq64: iterative restoring divider, one quotient bit per cycle over valid/ready.
// Define DIVIDER_SIGNED_EN to honour is_signed (truncating two's-complement division).
module divider_seq64 #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs, q_next, r_next, a_mag, b_mag, q_res, r_res;
  logic [WIDTH:0]   shifted, diff;
  logic [TAG_W-1:0] tag;
  logic             dbz;
  assign in_ready = state == IDLE;
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign q_next   = {quo[WIDTH-2:0], ~diff[WIDTH]};
  assign r_next   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
`ifdef DIVIDER_SIGNED_EN
  logic sa, sb, neg_q, neg_r;
  assign sa    = is_signed & dividend[WIDTH-1];
  assign sb    = is_signed & divisor[WIDTH-1];
  assign a_mag = sa ? -dividend : dividend;
  assign b_mag = sb ? -divisor : divisor;
  // divide-by-zero keeps the raw all-ones quotient; the remainder sign fixup restores the original dividend
  assign q_res = dbz ? '1 : neg_q ? -q_next : q_next;
  assign r_res = neg_r ? -r_next : r_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end
  end
`else
  logic unused_sign;
  assign unused_sign = is_signed;
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_res = q_next;
  assign r_res = r_next;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      tag         <= '0;
      dbz         <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      out_tag     <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          quo   <= a_mag;
          dvs   <= b_mag;
          rem   <= '0;
          tag   <= in_tag;
          dbz   <= divisor == '0;
          cnt   <= CW'(WIDTH - 1);
          state <= CALC;
        end
        CALC: begin
          quo <= q_next;
          rem <= r_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= q_res;
            remainder   <= r_res;
            out_tag     <= tag;
            div_by_zero <= dbz;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
